// File: rtl/sdram_arb_pkg.sv
// Shared types, default sizes and a reference round-robin helper for the SDRAM Wishbone arbiter.
package sdram_arb_pkg;

  localparam int ARB_N_MASTERS   = 4;
  localparam int ARB_AW          = 26;
  localparam int ARB_DW          = 32;
  localparam int ARB_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_ABORT} arb_state_e;

  // One-hot winner for up to 8 requesters, scanning upward from ptr+1 with wrap.
  function automatic logic [7:0] rr_next(input logic [7:0] req, input int unsigned ptr,
                                         input int unsigned n);
    int unsigned idx;
    rr_next = '0;
    for (int unsigned k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (req[idx[2:0]]) begin
        rr_next = '0;
        rr_next[idx[2:0]] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin encoder: rotate requests past the last winner, take the lowest, rotate back.
module sdram_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_start;
  int             w_first;
  int             w_idx;

  always_comb begin
    w_start = (int'(i_ptr) >= N - 1) ? 0 : int'(i_ptr) + 1;
    w_dbl   = {i_req, i_req} >> w_start;
    w_rot   = w_dbl[N-1:0];
    w_first = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_first = i;
    end
    w_idx = w_start + w_first;
    if (w_idx >= N) w_idx = w_idx - N;
    o_any = |i_req;
    o_idx = PW'(w_idx);
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = o_any && (w_idx == i);
    end
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller; grant held for a master's whole cycle.
// Define SDRAM_ARB_TIMEOUT_EN to add the stalled-ack timeout with m_err_o and the ABORT state.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_MASTERS   = ARB_N_MASTERS,
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC,
  localparam int SW         = DW / 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*AW-1:0] m_adr_i,
  input  logic [N_MASTERS*DW-1:0] m_dat_i,
  input  logic [N_MASTERS*SW-1:0] m_sel_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [SW-1:0]           s_sel_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    gnt_o
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e             r_state, w_state_nxt;
  logic [N_MASTERS-1:0]   r_gnt, w_gnt_nxt, w_pick_gnt;
  logic [PW-1:0]          r_gidx, w_gidx_nxt, w_pick_idx;
  logic [PW-1:0]          r_ptr, w_ptr_nxt;
  logic                   w_pick_any, w_granted, w_cyc_g, w_stb_g;

  sdram_rr_picker #(.N(N_MASTERS), .PW(PW)) u_picker (
    .i_req (m_cyc_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_granted = (r_state == ARB_GRANT);
  assign w_cyc_g   = w_granted & m_cyc_i[r_gidx];
  assign w_stb_g   = w_granted & m_stb_i[r_gidx];
  assign gnt_o     = r_gnt;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_tcnt;
  logic          w_timeout;

  // Fires during the TIMEOUT_CYC-th consecutive stalled strobe cycle.
  assign w_timeout = w_cyc_g && w_stb_g && !s_ack_i && (r_tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !w_granted || s_ack_i) r_tcnt <= '0;
    else if (w_stb_g)                      r_tcnt <= r_tcnt + 1'b1;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    s_cyc_o     = w_cyc_g;
    s_stb_o     = w_stb_g;
    s_we_o      = w_granted & m_we_i[r_gidx];
    s_adr_o     = w_granted ? m_adr_i[r_gidx*AW +: AW] : '0;
    s_dat_o     = w_granted ? m_dat_i[r_gidx*DW +: DW] : '0;
    s_sel_o     = w_granted ? m_sel_i[r_gidx*SW +: SW] : '0;
    m_dat_o     = w_granted ? s_dat_i : '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    if (w_granted) m_ack_o[r_gidx] = s_ack_i;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ARB_GRANT;
          w_gnt_nxt   = w_pick_gnt;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      ARB_GRANT: begin
        if (!m_cyc_i[r_gidx]) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = r_gidx;
          w_gnt_nxt   = '0;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (w_timeout) begin
          m_err_o[r_gidx] = 1'b1;
          w_state_nxt     = ARB_ABORT;
        end
`endif
      end
`ifdef SDRAM_ARB_TIMEOUT_EN
      ARB_ABORT: begin
        if (!m_cyc_i[r_gidx]) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = r_gidx;
          w_gnt_nxt   = '0;
        end
      end
`endif
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_ptr   <= PW'(N_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: vector table for grant rotation plus burst, reset and stall sequences.
module tb_sdram_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam logic [31:0] D0 = 32'hA5A5A5A5;
  localparam logic [31:0] D1 = 32'h11111111;
  localparam logic [31:0] D2 = 32'h22222222;
  localparam logic [31:0] D3 = 32'h33333333;
  localparam logic [31:0] SD = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic [SW-1:0]   s_sel_o;

  int n_chk  = 0;
  int n_fail = 0;

  sdram_wb_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic [3:0]  we;
    logic        sack;
    logic        exp_scyc;
    logic        exp_we;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_ack;
    logic [25:0] exp_adr;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic r, input logic [3:0] cyc, input logic [3:0] we,
                             input logic sack, input logic scyc, input logic swe,
                             input logic [3:0] gnt, input logic [3:0] ack,
                             input logic [25:0] adr, input logic [31:0] dat);
    vec_t t;
    t.rst = r; t.cyc = cyc; t.we = we; t.sack = sack; t.exp_scyc = scyc; t.exp_we = swe;
    t.exp_gnt = gnt; t.exp_ack = ack; t.exp_adr = adr; t.exp_dat = dat;
    return t;
  endfunction

  initial begin
    logic [31:0] dv [4];
    logic [3:0]  sv [4];
    dv = '{D0, D1, D2, D3};
    sv = '{4'hF, 4'h7, 4'h3, 4'h1};
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0; s_dat_i = SD;
    for (int i = 0; i < N; i++) begin
      m_adr_i[i*AW +: AW] = AW'(26'h100 * (i + 1));
      m_dat_i[i*DW +: DW] = dv[i];
      m_sel_i[i*SW +: SW] = sv[i];
    end

    // Test 1: single write from m0 after reset.
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'h1, 4'h1, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'h1, 4'h1, 1, 1, 1, 4'h1, 4'h1, 26'h100, D0));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h1, 4'h0, 26'h100, D0));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    // Test 2: all four request a read together; strict order 0,1,2,3.
    tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'hF, 4'h0, 1, 1, 0, 4'h1, 4'h1, 26'h100, D0));
    tbl.push_back(v(0, 4'hE, 4'h0, 0, 0, 0, 4'h1, 4'h0, 26'h100, D0));
    tbl.push_back(v(0, 4'hE, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'hE, 4'h0, 1, 1, 0, 4'h2, 4'h2, 26'h200, D1));
    tbl.push_back(v(0, 4'hC, 4'h0, 0, 0, 0, 4'h2, 4'h0, 26'h200, D1));
    tbl.push_back(v(0, 4'hC, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'hC, 4'h0, 1, 1, 0, 4'h4, 4'h4, 26'h300, D2));
    tbl.push_back(v(0, 4'h8, 4'h0, 0, 0, 0, 4'h4, 4'h0, 26'h300, D2));
    tbl.push_back(v(0, 4'h8, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'h8, 4'h0, 1, 1, 0, 4'h8, 4'h8, 26'h400, D3));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h8, 4'h0, 26'h400, D3));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    // Test 4: last grant was m3; m0 and m2 request -> m0 (wrap) then m2.
    tbl.push_back(v(0, 4'h5, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'h5, 4'h0, 1, 1, 0, 4'h1, 4'h1, 26'h100, D0));
    tbl.push_back(v(0, 4'h4, 4'h0, 0, 0, 0, 4'h1, 4'h0, 26'h100, D0));
    tbl.push_back(v(0, 4'h4, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));
    tbl.push_back(v(0, 4'h4, 4'h0, 1, 1, 0, 4'h4, 4'h4, 26'h300, D2));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h4, 4'h0, 26'h300, D2));
    tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 26'h0,   32'h0));

    // Reset state.
    tick(); tick();
    @(negedge clk);
    chk("reset s_cyc", 64'(s_cyc_o), 64'h0);
    chk("reset s_stb", 64'(s_stb_o), 64'h0);
    chk("reset gnt",   64'(gnt_o),   64'h0);
    chk("reset ack",   64'(m_ack_o), 64'h0);
    chk("reset err",   64'(m_err_o), 64'h0);
    chk("reset adr",   64'(s_adr_o), 64'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; m_cyc_i = tbl[i].cyc; m_stb_i = tbl[i].cyc;
      m_we_i = tbl[i].we; s_ack_i = tbl[i].sack;
      @(negedge clk);
      chk($sformatf("row%0d s_cyc", i), 64'(s_cyc_o), 64'(tbl[i].exp_scyc));
      chk($sformatf("row%0d s_stb", i), 64'(s_stb_o), 64'(tbl[i].exp_scyc));
      chk($sformatf("row%0d s_we", i),  64'(s_we_o),  64'(tbl[i].exp_we));
      chk($sformatf("row%0d gnt", i),   64'(gnt_o),   64'(tbl[i].exp_gnt));
      chk($sformatf("row%0d ack", i),   64'(m_ack_o), 64'(tbl[i].exp_ack));
      chk($sformatf("row%0d s_adr", i), 64'(s_adr_o), 64'(tbl[i].exp_adr));
      chk($sformatf("row%0d s_dat", i), 64'(s_dat_o), 64'(tbl[i].exp_dat));
      chk($sformatf("row%0d err", i),   64'(m_err_o), 64'h0);
      if (tbl[i].exp_ack != 4'h0) chk($sformatf("row%0d m_dat", i), 64'(m_dat_o), 64'(SD));
      tick();
    end
    rst = 1'b0; s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;

    // Stray ack while idle must not reach any master.
    s_ack_i = 1'b1;
    @(negedge clk);
    chk("stray ack", 64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b0;

    // Test 3: m1 burst of 8 while m2 waits; m1 drops cyc on the last acked beat.
    m_cyc_i = 4'h2; m_stb_i = 4'h2;
    tick();
    m_cyc_i = 4'h6; m_stb_i = 4'h6; s_ack_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) m_cyc_i = 4'h4;
      @(negedge clk);
      chk($sformatf("burst%0d gnt", b), 64'(gnt_o),   64'h2);
      chk($sformatf("burst%0d ack", b), 64'(m_ack_o), 64'h2);
      chk($sformatf("burst%0d s_cyc", b), 64'(s_cyc_o), (b == 7) ? 64'h0 : 64'h1);
      tick();
    end
    s_ack_i = 1'b0; m_stb_i = 4'h4;
    @(negedge clk);
    chk("burst gap gnt", 64'(gnt_o), 64'h0);
    tick();
    @(negedge clk);
    chk("burst m2 gnt", 64'(gnt_o),   64'h4);
    chk("burst m2 adr", 64'(s_adr_o), 64'h300);
    chk("burst m2 sel", 64'(s_sel_o), 64'h3);
    tick();
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Test 5: reset mid-transaction; pointer returns so m0 beats m3.
    m_cyc_i = 4'h1; m_stb_i = 4'h1;
    tick();
    @(negedge clk);
    chk("pre-reset s_cyc", 64'(s_cyc_o), 64'h1);
    tick();
    rst = 1'b1; s_ack_i = 1'b1; m_cyc_i = 4'h9; m_stb_i = 4'h9;
    tick();
    @(negedge clk);
    chk("mid-reset s_cyc", 64'(s_cyc_o), 64'h0);
    chk("mid-reset s_stb", 64'(s_stb_o), 64'h0);
    chk("mid-reset gnt",   64'(gnt_o),   64'h0);
    chk("mid-reset ack",   64'(m_ack_o), 64'h0);
    rst = 1'b0; s_ack_i = 1'b0;
    tick();
    @(negedge clk);
    chk("post-reset gnt", 64'(gnt_o), 64'h1);
    tick();
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Test 6: slave never acks m3.
    m_cyc_i = 4'h8; m_stb_i = 4'h8;
    tick();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
`ifdef SDRAM_ARB_TIMEOUT_EN
      chk($sformatf("stall%0d err", k),   64'(m_err_o), (k == TO) ? 64'h8 : 64'h0);
      chk($sformatf("stall%0d s_cyc", k), 64'(s_cyc_o), (k <= TO) ? 64'h1 : 64'h0);
`else
      chk($sformatf("stall%0d err", k),   64'(m_err_o), 64'h0);
      chk($sformatf("stall%0d s_cyc", k), 64'(s_cyc_o), 64'h1);
`endif
      tick();
    end
    m_cyc_i = '0; m_stb_i = '0;
    tick();
    @(negedge clk);
    chk("stall release gnt", 64'(gnt_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
